// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running 11-bit horizontal/vertical counters decoded into
// registered hsync, vsync, video_active, pix_x/pix_y, line_start and frame_start.
// Optional feature macro VGA_FRAME_CNT_EN adds a 16-bit frame counter output frame_cnt_o.
// H_TOTAL and V_TOTAL must not exceed 2048.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pix_en_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        video_active_o,
  output logic [9:0]  pix_x_o,
  output logic [9:0]  pix_y_o,
  output logic        line_start_o,
`ifdef VGA_FRAME_CNT_EN
  output logic        frame_start_o,
  output logic [15:0] frame_cnt_o
`else
  output logic        frame_start_o
`endif
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast = 11'(HTotal - 1);
  localparam logic [10:0] VLast = 11'(VTotal - 1);

  // Compares run at 12 bits so a sync pulse ending exactly at 2048 still decodes.
  localparam logic [11:0] HActEnd  = 12'(H_ACTIVE);
  localparam logic [11:0] HSyncBeg = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HSyncEnd = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VActEnd  = 12'(V_ACTIVE);
  localparam logic [11:0] VSyncBeg = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VSyncEnd = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic [11:0] h_ext, v_ext;
  logic        h_vis, v_vis, h_in_sync, v_in_sync;

  assign h_ext     = {1'b0, h_cnt_q};
  assign v_ext     = {1'b0, v_cnt_q};
  assign h_vis     = h_ext < HActEnd;
  assign v_vis     = v_ext < VActEnd;
  assign h_in_sync = (h_ext >= HSyncBeg) && (h_ext < HSyncEnd);
  assign v_in_sync = (v_ext >= VSyncBeg) && (v_ext < VSyncEnd);

  // Next-state: advance counters and decode the pre-increment position on enabled cycles.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en_i) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
      hsync_d       = h_in_sync ? H_POL : ~H_POL;
      vsync_d       = v_in_sync ? V_POL : ~V_POL;
      active_d      = h_vis && v_vis;
      pix_x_d       = (h_vis && v_vis) ? h_cnt_q[9:0] : '0;
      pix_y_d       = (h_vis && v_vis) ? v_cnt_q[9:0] : '0;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // State and output registers; async assert, release synchronised upstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o        = hsync_q;
  assign vsync_o        = vsync_q;
  assign video_active_o = active_q;
  assign pix_x_o        = pix_x_q;
  assign pix_y_o        = pix_y_q;
  assign line_start_o   = line_start_q;
  assign frame_start_o  = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps on the same edge that raises frame_start, wrapping naturally.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (25 x 13) so several frames fit in the run.
// Fixed vectors from reset, hand sequences for pix_en toggling, async reset and frame wrap,
// then randomized pix_en/reset against an arithmetic position model.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;  // 25
  localparam int VT = VA + VF + VS + VB;  // 13
  localparam int FT = HT * VT;            // 325
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pix_en_i = 1'b0;
  logic        hsync_o, vsync_o, video_active_o, line_start_o, frame_start_o;
  logic [9:0]  pix_x_o, pix_y_o;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pix_en_i      (pix_en_i),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .video_active_o(video_active_o),
    .pix_x_o       (pix_x_o),
    .pix_y_o       (pix_y_o),
    .line_start_o  (line_start_o),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt_o   (frame_cnt_o),
`endif
    .frame_start_o (frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: linear position within the frame, decoded with plain arithmetic.
  int m_pos, m_x, m_y, m_fc;
  bit m_hs, m_vs, m_act, m_ls, m_fs;

  function automatic void model_reset();
    m_pos = 0; m_x = 0; m_y = 0;
    m_hs = ~HPOL; m_vs = ~VPOL; m_act = 0; m_ls = 0; m_fs = 0;
    m_fc = 0;
  endfunction

  function automatic void model_edge(bit en);
    int h, v;
    m_ls = 0;
    m_fs = 0;
    if (!en) return;
    h = m_pos % HT;
    v = m_pos / HT;
    m_act = (h < HA) && (v < VA);
    m_x   = m_act ? h : 0;
    m_y   = m_act ? v : 0;
    m_hs  = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
    m_vs  = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
    m_ls  = (h == 0);
    m_fs  = (m_pos == 0);
    if (m_fs) m_fc = (m_fc + 1) % 65536;
    m_pos = (m_pos + 1) % FT;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"},  int'(pix_x_o),        m_x);
    check({tag, ".y"},  int'(pix_y_o),        m_y);
    check({tag, ".act"}, int'(video_active_o), int'(m_act));
    check({tag, ".hs"}, int'(hsync_o),        int'(m_hs));
    check({tag, ".vs"}, int'(vsync_o),        int'(m_vs));
    check({tag, ".ls"}, int'(line_start_o),   int'(m_ls));
    check({tag, ".fs"}, int'(frame_start_o),  int'(m_fs));
`ifdef VGA_FRAME_CNT_EN
    check({tag, ".fc"}, int'(frame_cnt_o),    m_fc);
`endif
  endtask

  // One clock with the given enable; inputs change and outputs are sampled 1 after the edge.
  task automatic step(input bit en);
    pix_en_i = en;
    @(posedge clk_i);
    if (!rst_i) model_edge(en);
    #1;
  endtask

  task automatic do_reset();
    pix_en_i = 1'b0;
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  typedef struct {
    int steps;
    int x;
    int y;
    bit act, hs, vs, ls, fs;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int ls_cnt, en_since_ls;
    bit ls_seen;

    // Expected output after N enabled edges from reset (output shows position N-1).
    tbl[0]  = '{0,   0,  0, 0, 1, 1, 0, 0};  // reset values
    tbl[1]  = '{1,   0,  0, 1, 1, 1, 1, 1};  // (0,0), both pulses
    tbl[2]  = '{2,   1,  0, 1, 1, 1, 0, 0};
    tbl[3]  = '{16, 15,  0, 1, 1, 1, 0, 0};  // last visible column
    tbl[4]  = '{17,  0,  0, 0, 1, 1, 0, 0};  // front porch
    tbl[5]  = '{19,  0,  0, 0, 0, 1, 0, 0};  // hsync first column
    tbl[6]  = '{21,  0,  0, 0, 0, 1, 0, 0};  // hsync last column
    tbl[7]  = '{22,  0,  0, 0, 1, 1, 0, 0};  // back porch
    tbl[8]  = '{26,  0,  1, 1, 1, 1, 1, 0};  // second line start
    tbl[9]  = '{226, 0,  0, 0, 1, 0, 1, 0};  // first vsync line
    tbl[10] = '{325, 0,  0, 0, 1, 1, 0, 0};  // last pixel of frame
    tbl[11] = '{326, 0,  0, 1, 1, 1, 1, 1};  // wrap to (0,0)

    for (int i = 0; i < 12; i++) begin
      do_reset();
      for (int s = 0; s < tbl[i].steps; s++) step(1'b1);
      check($sformatf("tbl%0d.x", i),   int'(pix_x_o),        tbl[i].x);
      check($sformatf("tbl%0d.y", i),   int'(pix_y_o),        tbl[i].y);
      check($sformatf("tbl%0d.act", i), int'(video_active_o), int'(tbl[i].act));
      check($sformatf("tbl%0d.hs", i),  int'(hsync_o),        int'(tbl[i].hs));
      check($sformatf("tbl%0d.vs", i),  int'(vsync_o),        int'(tbl[i].vs));
      check($sformatf("tbl%0d.ls", i),  int'(line_start_o),   int'(tbl[i].ls));
      check($sformatf("tbl%0d.fs", i),  int'(frame_start_o),  int'(tbl[i].fs));
    end

    // pix_en toggling across the line boundary: holds on 0, line_start exactly once.
    do_reset();
    for (int s = 0; s < 24; s++) step(1'b1);
    ls_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(k % 2 == 0);
      check_model($sformatf("tog%0d", k));
      if (line_start_o) ls_cnt++;
    end
    check("tog.ls_count", ls_cnt, 1);
    check("tog.y_held", int'(pix_y_o), 1);

    // Async reset mid-line at pixel (10,5).
    do_reset();
    for (int s = 0; s < 5 * HT + 10 + 1; s++) step(1'b1);
    check_model("pre_rst");
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(1'b1);
    check("rst_rel.x", int'(pix_x_o), 0);
    check("rst_rel.y", int'(pix_y_o), 0);
    check("rst_rel.fs", int'(frame_start_o), 1);
    check_model("rst_rel");

`ifdef VGA_FRAME_CNT_EN
    // Three frame_starts from reset, then wrap from a forced 0xFFFF.
    do_reset();
    for (int s = 0; s < 2 * FT + 1; s++) step(1'b1);
    check("fc.three", int'(frame_cnt_o), 3);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_fc = 16'hFFFF;
    for (int s = 0; s < FT; s++) step(1'b1);
    check("fc.fs", int'(frame_start_o), 1);
    check("fc.wrap", int'(frame_cnt_o), 0);
`endif

    // Randomized enable with rare resets, checked every cycle; also the enabled-cycle
    // count between consecutive line_start pulses must equal one full line.
    do_reset();
    ls_seen = 0;
    en_since_ls = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        ls_seen = 0;
        check_model("rnd_rst");
      end else begin
        bit en;
        en = ($urandom_range(0, 3) != 0);
        step(en);
        check_model("rnd");
        if (en) en_since_ls++;
        if (line_start_o) begin
          if (ls_seen) check("rnd.line_len", en_since_ls, HT);
          ls_seen = 1;
          en_since_ls = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
